// File: rtl/controller_if.sv
// Control bundle between the multicycle RISC-V controller and its datapath.
// The halt flag exists only when ILLEGAL_HALT_EN is defined.
interface controller_if;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       zero;
    logic       sign;

    logic       pc_w;
    logic       oldpc_w;
    logic       IR_w;
    logic       memwrite;
    logic       regwrite;
    logic       adr_src;
    logic [2:0] imm_src;
    logic [2:0] ALUcontrol;
    logic [1:0] Alu_srcA;
    logic [1:0] Alu_srcB;
    logic [1:0] result_src;
`ifdef ILLEGAL_HALT_EN
    logic       halt;
`endif

    modport master (
        input  opcode, f3, f7, zero, sign,
        output pc_w, oldpc_w, IR_w, memwrite, regwrite, adr_src,
        output imm_src, ALUcontrol, Alu_srcA, Alu_srcB, result_src
`ifdef ILLEGAL_HALT_EN
        , output halt
`endif
    );

    modport slave (
        output opcode, f3, f7, zero, sign,
        input  pc_w, oldpc_w, IR_w, memwrite, regwrite, adr_src,
        input  imm_src, ALUcontrol, Alu_srcA, Alu_srcB, result_src
`ifdef ILLEGAL_HALT_EN
        , input halt
`endif
    );
endinterface

// File: rtl/controller.sv
// Multicycle RISC-V control FSM. Define ILLEGAL_HALT_EN to trap unrecognised
// opcodes in a HALT state (with halt output) instead of refetching.
module controller (
    input  logic         clk,
    input  logic         rst,
    controller_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, LINKWB, LUI
`ifdef ILLEGAL_HALT_EN
        , HALT
`endif
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                           IMM_J = 3'b011, IMM_U = 3'b100;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                           ALU_OR  = 3'b011, ALU_SLT = 3'b100, ALU_XOR = 3'b101;
    localparam logic [1:0] SA_PC = 2'd0, SA_OLDPC = 2'd1, SA_A = 2'd2;
    localparam logic [1:0] SB_B = 2'd0, SB_IMM = 2'd1, SB_4 = 2'd2;
    localparam logic [1:0] RS_ALUREG = 2'd0, RS_MDR = 2'd1, RS_ALUOUT = 2'd2, RS_IMM = 2'd3;

    state_t     state, state_nx;
    logic       pc_w_c, oldpc_w_c, ir_w_c, memwrite_c, regwrite_c;
    logic       adr_src_c;
    logic [2:0] imm_src_c, alu_c;
    logic [1:0] srca_c, srcb_c, res_c;
    logic       unused_f7;

    assign unused_f7 = ^{bus.f7[6], bus.f7[4:0]};

    function automatic logic [2:0] alu_dec(input logic [2:0] f, input logic sub_sel);
        case (f)
            3'b000:  return sub_sel ? ALU_SUB : ALU_ADD;
            3'b111:  return ALU_AND;
            3'b110:  return ALU_OR;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx   = FETCH;
        pc_w_c     = 1'b0;
        oldpc_w_c  = 1'b0;
        ir_w_c     = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        adr_src_c  = 1'b0;
        imm_src_c  = IMM_I;
        alu_c      = ALU_ADD;
        srca_c     = SA_PC;
        srcb_c     = SB_B;
        res_c      = RS_ALUREG;
        case (state)
            FETCH: begin
                ir_w_c    = 1'b1;
                oldpc_w_c = 1'b1;
                srcb_c    = SB_4;
                res_c     = RS_ALUOUT;
                pc_w_c    = 1'b1;
                state_nx  = DECODE;
            end
            DECODE: begin
                srca_c = SA_OLDPC;
                srcb_c = SB_IMM;
                case (bus.opcode)
                    OP_LOAD:  state_nx = MEMADR;
                    OP_STORE: begin imm_src_c = IMM_S; state_nx = MEMADR; end
                    OP_R:     state_nx = EXECR;
                    OP_I:     state_nx = EXECI;
                    OP_B:     begin imm_src_c = IMM_B; state_nx = BRANCH; end
                    OP_JAL:   begin imm_src_c = IMM_J; state_nx = JAL; end
                    OP_JALR:  state_nx = JALR;
                    OP_LUI:   begin imm_src_c = IMM_U; state_nx = LUI; end
`ifdef ILLEGAL_HALT_EN
                    default:  state_nx = HALT;
`else
                    default:  state_nx = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                srca_c    = SA_A;
                srcb_c    = SB_IMM;
                imm_src_c = (bus.opcode == OP_LOAD) ? IMM_I : IMM_S;
                state_nx  = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src_c = 1'b1;
                state_nx  = MEMWB;
            end
            MEMWB: begin
                res_c      = RS_MDR;
                regwrite_c = 1'b1;
            end
            MEMWRITE: begin
                adr_src_c  = 1'b1;
                memwrite_c = 1'b1;
            end
            EXECR: begin
                srca_c   = SA_A;
                alu_c    = alu_dec(bus.f3, bus.f7[5]);
                state_nx = ALUWB;
            end
            EXECI: begin
                srca_c   = SA_A;
                srcb_c   = SB_IMM;
                alu_c    = alu_dec(bus.f3, 1'b0);
                state_nx = ALUWB;
            end
            ALUWB: regwrite_c = 1'b1;
            BRANCH: begin
                srca_c = SA_A;
                alu_c  = ALU_SUB;
                case (bus.f3)
                    3'b000:  pc_w_c = bus.zero;
                    3'b001:  pc_w_c = !bus.zero;
                    3'b100:  pc_w_c = bus.sign;
                    3'b101:  pc_w_c = !bus.sign;
                    default: pc_w_c = 1'b0;
                endcase
            end
            JAL: begin
                pc_w_c   = 1'b1;
                state_nx = LINKWB;
            end
            JALR: begin
                srca_c   = SA_A;
                srcb_c   = SB_IMM;
                res_c    = RS_ALUOUT;
                pc_w_c   = 1'b1;
                state_nx = LINKWB;
            end
            LINKWB: begin
                srca_c     = SA_OLDPC;
                srcb_c     = SB_4;
                res_c      = RS_ALUOUT;
                regwrite_c = 1'b1;
            end
            LUI: begin
                imm_src_c  = IMM_U;
                res_c      = RS_IMM;
                regwrite_c = 1'b1;
            end
`ifdef ILLEGAL_HALT_EN
            HALT: state_nx = HALT;
`endif
            default: state_nx = FETCH;
        endcase
    end

    // Reset forces FETCH asynchronously; its write enables are masked until release.
    assign bus.pc_w       = pc_w_c & rst;
    assign bus.oldpc_w    = oldpc_w_c & rst;
    assign bus.IR_w       = ir_w_c & rst;
    assign bus.memwrite   = memwrite_c & rst;
    assign bus.regwrite   = regwrite_c & rst;
    assign bus.adr_src    = adr_src_c;
    assign bus.imm_src    = imm_src_c;
    assign bus.ALUcontrol = alu_c;
    assign bus.Alu_srcA   = srca_c;
    assign bus.Alu_srcB   = srcb_c;
    assign bus.result_src = res_c;
`ifdef ILLEGAL_HALT_EN
    assign bus.halt       = (state == HALT);
`endif
endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: directed vector table, reset/halt
// sequences and randomized instruction streams against a per-instruction model.
module tb_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    controller_if bus ();
    controller dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_w, oldpc_w, ir_w, memwrite, regwrite, adr_src;
        logic [2:0] imm, alu;
        logic [1:0] srca, srcb, res;
    } ctl_t;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z, s;
        int         cpi;
    } vec_t;

    localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_I = 3, C_BR = 4,
                   C_JAL = 5, C_JALR = 6, C_LUI = 7, C_ILL = 8;

    logic [6:0] legal_ops [8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37};
    // ALU code selected by f3 (index) for register/immediate arithmetic
    logic [2:0] f3_alu [8] = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd5, 3'd0, 3'd3, 3'd2};

    function automatic int cls_of(input logic [6:0] op);
        for (int unsigned i = 0; i < 8; i++)
            if (legal_ops[i] == op) return int'(i);
        return C_ILL;
    endfunction

    function automatic ctl_t actual();
        ctl_t a;
        a = '{pc_w: bus.pc_w, oldpc_w: bus.oldpc_w, ir_w: bus.IR_w, memwrite: bus.memwrite,
              regwrite: bus.regwrite, adr_src: bus.adr_src, imm: bus.imm_src,
              alu: bus.ALUcontrol, srca: bus.Alu_srcA, srcb: bus.Alu_srcB, res: bus.result_src};
        return a;
    endfunction

    // Expected controls for cycle 'step' of one instruction (0 = fetch).
    function automatic void model(input int cls, input int step, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic z, input logic s,
                                  output ctl_t e, output bit last);
        e = '0;
        last = 1'b0;
        if (step == 0) begin
            e.ir_w = 1; e.oldpc_w = 1; e.pc_w = 1; e.srcb = 2; e.res = 2;
            return;
        end
        if (step == 1) begin
            e.srca = 1; e.srcb = 1;
            case (cls)
                C_STORE: e.imm = 3'd1;
                C_BR:    e.imm = 3'd2;
                C_JAL:   e.imm = 3'd3;
                C_LUI:   e.imm = 3'd4;
                default: e.imm = 3'd0;
            endcase
            last = (cls == C_ILL);
            return;
        end
        case (cls)
            C_LOAD, C_STORE: begin
                if (step == 2) begin
                    e.srca = 2; e.srcb = 1; e.imm = (cls == C_STORE) ? 3'd1 : 3'd0;
                end else if (step == 3) begin
                    e.adr_src = 1; e.memwrite = (cls == C_STORE);
                    last = (cls == C_STORE);
                end else begin
                    e.res = 1; e.regwrite = 1; last = 1;
                end
            end
            C_R, C_I: begin
                if (step == 2) begin
                    e.srca = 2;
                    e.srcb = (cls == C_I) ? 2'd1 : 2'd0;
                    e.alu  = (cls == C_R && f3 == 3'b000 && f7[5]) ? 3'd1 : f3_alu[f3];
                end else begin
                    e.regwrite = 1; last = 1;
                end
            end
            C_BR: begin
                e.srca = 2; e.alu = 3'd1; last = 1;
                e.pc_w = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z :
                         (f3 == 3'b100) ? s : (f3 == 3'b101) ? !s : 1'b0;
            end
            C_JAL, C_JALR: begin
                if (step == 2) begin
                    e.pc_w = 1;
                    if (cls == C_JALR) begin e.srca = 2; e.srcb = 1; e.res = 2; end
                end else begin
                    e.srca = 1; e.srcb = 2; e.res = 2; e.regwrite = 1; last = 1;
                end
            end
            C_LUI: begin
                e.imm = 3'd4; e.res = 3; e.regwrite = 1; last = 1;
            end
            default: last = 1;
        endcase
    endfunction

    task automatic check(input string name, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Runs up to 'limit' cycles of one instruction, checking each against the model.
    task automatic run_steps(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input bit fix_zs, input logic z,
                             input logic s, input int limit, output int cycles);
        ctl_t e;
        bit   last;
        int   cls;
        cls = cls_of(op);
        cycles = 0;
        last = 1'b0;
        while (!last && cycles < limit) begin
            @(negedge clk);
            bus.opcode = op;
            bus.f3     = f3;
            bus.f7     = f7;
            bus.zero   = fix_zs ? z : 1'($urandom);
            bus.sign   = fix_zs ? s : 1'($urandom);
            #1;
            model(cls, cycles, f3, f7, bus.zero, bus.sign, e, last);
            check($sformatf("%s step%0d", name, cycles), actual(), e);
            cycles++;
        end
    endtask

    // Full instruction; reports whether the DUT is back in fetch right after it.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input bit fix_zs, input logic z,
                             input logic s, output int cycles, output bit refetch);
        run_steps(name, op, f3, f7, fix_zs, z, s, 8, cycles);
        @(posedge clk);
        #1;
        refetch = (bus.IR_w === 1'b1);
    endtask

    function automatic ctl_t reset_ctl();
        ctl_t r = '0;
        r.srcb = 2; r.res = 2;
        return r;
    endfunction

    vec_t       vecs[$];
    int         cyc;
    bit         rf;
    logic [31:0] add_word;
    logic [6:0] rop, rf7;
    logic [2:0] rf3;

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        add_word = 32'h002081B3;
        vecs.push_back('{"add_x3", add_word[6:0], add_word[14:12], add_word[31:25], 1'b0, 1'b0, 4});
        vecs.push_back('{"sub",    7'h33, 3'b000, 7'h20, 1'b0, 1'b0, 4});
        vecs.push_back('{"and",    7'h33, 3'b111, 7'h00, 1'b0, 1'b0, 4});
        vecs.push_back('{"slt",    7'h33, 3'b010, 7'h00, 1'b0, 1'b0, 4});
        vecs.push_back('{"addi_f7",7'h13, 3'b000, 7'h20, 1'b0, 1'b0, 4});
        vecs.push_back('{"xori",   7'h13, 3'b100, 7'h00, 1'b0, 1'b0, 4});
        vecs.push_back('{"lw",     7'h03, 3'b010, 7'h00, 1'b0, 1'b0, 5});
        vecs.push_back('{"sw",     7'h23, 3'b010, 7'h00, 1'b0, 1'b0, 4});
        vecs.push_back('{"beq_t",  7'h63, 3'b000, 7'h00, 1'b1, 1'b0, 3});
        vecs.push_back('{"beq_nt", 7'h63, 3'b000, 7'h00, 1'b0, 1'b0, 3});
        vecs.push_back('{"bne_z",  7'h63, 3'b001, 7'h00, 1'b1, 1'b0, 3});
        vecs.push_back('{"blt_s",  7'h63, 3'b100, 7'h00, 1'b0, 1'b1, 3});
        vecs.push_back('{"bge_s",  7'h63, 3'b101, 7'h00, 1'b1, 1'b1, 3});
        vecs.push_back('{"br_f3_2",7'h63, 3'b010, 7'h00, 1'b1, 1'b1, 3});
        vecs.push_back('{"jal",    7'h6F, 3'b000, 7'h00, 1'b0, 1'b0, 4});
        vecs.push_back('{"jalr",   7'h67, 3'b000, 7'h00, 1'b0, 1'b0, 4});
        vecs.push_back('{"lui",    7'h37, 3'b101, 7'h00, 1'b0, 1'b0, 3});
`ifndef ILLEGAL_HALT_EN
        vecs.push_back('{"illegal",7'h00, 3'b000, 7'h00, 1'b0, 1'b0, 2});
`endif

        bus.opcode = '0; bus.f3 = '0; bus.f7 = '0; bus.zero = 1'b0; bus.sign = 1'b0;

        // Reset held: FETCH selects with all write enables masked, across an edge.
        #2;
        check("reset_hold", actual(), reset_ctl());
        @(posedge clk);
        #1;
        check("reset_hold_edge", actual(), reset_ctl());
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7, 1'b1,
                      vecs[i].z, vecs[i].s, cyc, rf);
            checks++;
            if (!(rf && cyc == vecs[i].cpi)) begin
                errors++;
                $display("FAIL cpi_%s got=%0d refetch=%0d exp=%0d", vecs[i].name, cyc, rf, vecs[i].cpi);
            end
        end

        // Reset asserted mid-store: memwrite must drop with no clock edge.
        run_steps("sw_pre_rst", 7'h23, 3'b010, 7'h00, 1'b1, 1'b0, 1'b0, 4, cyc);
        #1;
        rst = 1'b0;
        #1;
        check("rst_mid_store", actual(), reset_ctl());
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr("lw_after_rst", 7'h03, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0, cyc, rf);
        checks++;
        if (!rf) begin
            errors++;
            $display("FAIL refetch_after_rst got=%0d exp=1", rf);
        end

        // Randomized instruction stream with per-cycle random flags.
        for (int n = 0; n < 300; n++) begin
            rop = legal_ops[$urandom_range(0, 7)];
`ifndef ILLEGAL_HALT_EN
            if ($urandom_range(0, 9) == 0) rop = 7'($urandom);
`endif
            rf3 = 3'($urandom);
            rf7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
            run_instr($sformatf("rnd%0d_op%02h", n, rop), rop, rf3, rf7, 1'b0, 1'b0, 1'b0, cyc, rf);
            checks++;
            if (!rf) begin
                errors++;
                $display("FAIL rnd%0d_refetch got=%0d exp=1", n, rf);
            end
        end

`ifdef ILLEGAL_HALT_EN
        // Illegal opcode traps in HALT with every write enable off until reset.
        run_steps("ill_halt", 7'h00, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0, 2, cyc);
        checks++;
        if (bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_in_decode got=%b exp=0", bus.halt);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({bus.pc_w, bus.oldpc_w, bus.IR_w, bus.memwrite, bus.regwrite, bus.halt} !== 6'b000001) begin
                errors++;
                $display("FAIL halt_cycle%0d got=%b exp=000001", k,
                         {bus.pc_w, bus.oldpc_w, bus.IR_w, bus.memwrite, bus.regwrite, bus.halt});
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.halt !== 1'b0) begin
            errors++;
            $display("FAIL halt_cleared got=%b exp=0", bus.halt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_instr("add_after_halt", 7'h33, 3'b000, 7'h00, 1'b1, 1'b0, 1'b0, cyc, rf);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
